// File: rtl/sum4b_seq_ctrl.sv
// Nibble-serial adder sequencer: drives one external 4-bit adder twice per nibble
// (operand add, then carry-in add) to build a NIBBLES*4-bit sum with carry out.
module sum4b_seq_ctrl #(
   parameter int NIBBLES = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [4*NIBBLES-1:0] a,
   input  logic [4*NIBBLES-1:0] b,
   output logic                 busy,
   output logic                 done,
   output logic [4*NIBBLES-1:0] sum,
   output logic                 cout,
   output logic [3:0]           add_x,
   output logic [3:0]           add_y,
   input  logic [3:0]           add_z,
   input  logic                 add_co
);

   localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ADD_XY = 2'd1,
      ADD_CI = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t                    state;
   logic [NIBBLES-1:0][3:0]   a_op;
   logic [NIBBLES-1:0][3:0]   b_op;
   logic [NIBBLES-1:0][3:0]   sum_q;
   logic [IW-1:0]             idx;
   logic                      carry;
   logic                      c1;
   logic [3:0]                p;
   logic                      last_nib;

   assign last_nib = (idx == IW'(NIBBLES - 1));
   assign sum      = sum_q;

   // Adder operands: raw nibbles in the first pass, partial sum plus carry in the second.
   always_comb begin
      add_x = 4'd0;
      add_y = 4'd0;
      case (state)
         ADD_XY: begin
            add_x = a_op[idx];
            add_y = b_op[idx];
         end
         ADD_CI: begin
            add_x = p;
            add_y = {3'b000, carry};
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         sum_q <= '0;
         cout  <= 1'b0;
         a_op  <= '0;
         b_op  <= '0;
         idx   <= '0;
         carry <= 1'b0;
         c1    <= 1'b0;
         p     <= 4'd0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_op  <= a;
                  b_op  <= b;
                  idx   <= '0;
                  carry <= 1'b0;
                  busy  <= 1'b1;
                  state <= ADD_XY;
               end
            end
            ADD_XY: begin
               p     <= add_z;
               c1    <= add_co;
               state <= ADD_CI;
            end
            ADD_CI: begin
               // c1 and add_co are mutually exclusive, so OR is the true carry out.
               sum_q[idx] <= add_z;
               carry      <= c1 | add_co;
               if (last_nib) begin
                  cout  <= c1 | add_co;
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  idx   <= idx + 1'b1;
                  state <= ADD_XY;
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sum4b_seq_ctrl.sv
// Directed and random checks of sum4b_seq_ctrl paired with a behavioural 4-bit adder.
module tb_sum4b_seq_ctrl;
   localparam int NIBBLES = 4;
   localparam int W       = 4 * NIBBLES;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         busy, done, cout, add_co;
   logic [W-1:0] sum;
   logic [3:0]   add_x, add_y, add_z;
   logic [4:0]   add_res;

   typedef struct packed {
      logic [W-1:0] es;
      logic         ec;
   } exp_t;

   exp_t sb[$];
   int   compared   = 0;
   int   mismatched = 0;

   sum4b_seq_ctrl #(.NIBBLES(NIBBLES)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
      .busy(busy), .done(done), .sum(sum), .cout(cout),
      .add_x(add_x), .add_y(add_y), .add_z(add_z), .add_co(add_co)
   );

   // Stand-in for the external sum4b instance.
   assign add_res = {1'b0, add_x} + {1'b0, add_y};
   assign add_z   = add_res[3:0];
   assign add_co  = add_res[4];

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp)
      else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input logic [W-1:0] x, input logic [W-1:0] y);
      logic [W:0] s;
      s = {1'b0, x} + {1'b0, y};
      sb.push_back('{es: s[W-1:0], ec: s[W]});
   endtask

   task automatic check_result(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         compared++;
         mismatched++;
         $error("FAIL %s_sb_empty: observed done with no expectation queued", tag);
      end else begin
         e = sb.pop_front();
         chk({tag, "_sum"}, 32'(sum), 32'(e.es));
         chk({tag, "_cout"}, 32'(cout), 32'(e.ec));
      end
   endtask

   // Carry entering nibble j of x+y.
   function automatic logic cin_of(input logic [W-1:0] x, input logic [W-1:0] y, input int j);
      logic [W:0] m, s;
      m = ((W+1)'(1) << (4 * j)) - (W+1)'(1);
      s = ({1'b0, x} & m) + ({1'b0, y} & m);
      return s[4*j];
   endfunction

   // Caller sits 1 time unit after a rising edge with the DUT in IDLE.
   task automatic run_op(input string tag, input logic [W-1:0] oa, input logic [W-1:0] ob,
                         input bit noisy);
      int j;
      start = 1'b1;
      a     = oa;
      b     = ob;
      push_exp(oa, ob);
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i <= 2 * NIBBLES; i++) begin
         if (i > 0) begin
            @(posedge clk); #1;
         end
         j = i / 2;
         if (i < 2 * NIBBLES) begin
            chk($sformatf("%s_busy_%0d", tag, i), 32'(busy), 32'd1);
            chk($sformatf("%s_early_done_%0d", tag, i), 32'(done), 32'd0);
            if (i % 2 == 0) begin
               chk($sformatf("%s_xy_x_%0d", tag, j), 32'(add_x), 32'(oa[4*j +: 4]));
               chk($sformatf("%s_xy_y_%0d", tag, j), 32'(add_y), 32'(ob[4*j +: 4]));
            end else begin
               chk($sformatf("%s_ci_y_%0d", tag, j), 32'(add_y), 32'(cin_of(oa, ob, j)));
            end
         end else begin
            chk({tag, "_done"}, 32'(done), 32'd1);
            chk({tag, "_busy_done"}, 32'(busy), 32'd1);
            check_result(tag);
         end
         if (noisy) begin
            a     = W'($urandom);
            b     = W'($urandom);
            start = 1'($urandom_range(0, 1));
         end
      end
      start = 1'b0;
      @(posedge clk); #1;
      chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
      chk({tag, "_idle_done"}, 32'(done), 32'd0);
      chk({tag, "_idle_x"}, 32'(add_x), 32'd0);
      chk({tag, "_idle_y"}, 32'(add_y), 32'd0);
      chk({tag, "_held_sum"}, 32'(sum), 32'(W'(oa + ob)));
   endtask

   initial begin
      // Reset state
      #12;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_sum", 32'(sum), 32'd0);
      chk("rst_cout", 32'(cout), 32'd0);
      chk("rst_x", 32'(add_x), 32'd0);
      chk("rst_y", 32'(add_y), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_busy", 32'(busy), 32'd0);

      run_op("t1", 16'h1234, 16'h4321, 1'b0);
      run_op("t2", 16'hFFFF, 16'h0001, 1'b0);
      run_op("t3a", 16'hFFFF, 16'hFFFF, 1'b0);
      run_op("t3b", 16'h0000, 16'h0000, 1'b0);

      // Start held high: one accept in IDLE, next only after DONE has returned to IDLE.
      start = 1'b1;
      a     = 16'h000F;
      b     = 16'h0001;
      push_exp(16'h000F, 16'h0001);
      push_exp(16'h000F, 16'h0001);
      for (int c = 1; c <= 30; c++) begin
         @(posedge clk); #1;
         if (c == 20) start = 1'b0;
         chk($sformatf("t4_done_%0d", c), 32'(done), 32'((c == 9) || (c == 19)));
         chk($sformatf("t4_busy_%0d", c), 32'(busy),
             32'(((c >= 1) && (c <= 9)) || ((c >= 11) && (c <= 19))));
         if (done) check_result("t4");
      end
      chk("t4_ops_left", 32'(sb.size()), 32'd0);

      // Asynchronous reset during the carry pass of nibble 2.
      start = 1'b1;
      a     = 16'h1234;
      b     = 16'h4321;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("t5_in_ci", 32'(add_y), 32'(cin_of(16'h1234, 16'h4321, 2)));
      chk("t5_in_ci_x", 32'(add_x), 32'h5);
      #2;
      rst = 1'b0;
      #1;
      chk("t5_busy", 32'(busy), 32'd0);
      chk("t5_done", 32'(done), 32'd0);
      chk("t5_sum", 32'(sum), 32'd0);
      chk("t5_cout", 32'(cout), 32'd0);
      chk("t5_x", 32'(add_x), 32'd0);
      chk("t5_y", 32'(add_y), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("t5_idle_after", 32'(busy), 32'd0);
      run_op("t5_restart", 16'hABCD, 16'h5678, 1'b0);

      // Random operands, with inputs and start toggling while busy.
      for (int n = 0; n < 1000; n++)
         run_op("t6", W'($urandom), W'($urandom), 1'b1);

      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
